sync_rx_fifo: RTL and testbench

Synchronous, fully parametrised successor to the event-clocked receive FIFO. It buffers received UART words between the receiver and the host/register interface. All state moves on one clock, driven by single-cycle push/pop strobes. It adds simultaneous push+pop, a programmable almost-full threshold, an occupancy count, sticky overflow/underflow flags with clear, and an optional first-word-fall-through read mode.

---
 rtl/sync_fifo_pkg.sv | 22 ++
 rtl/fifo_dpram.sv | 42 ++++
 rtl/sync_rx_fifo.sv | 137 +++++++++++++
 tb/tb_sync_rx_fifo.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the synchronous receive FIFO.
// Optional FWFT read mode is selected by SYNC_RX_FIFO_FWFT_EN.
package sync_fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 4;
  localparam int DEPTH_DEF = 1 << FIFO_WIDTH_DEF;

  typedef logic [FIFO_WIDTH_DEF:0] fifo_cnt_t;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_flags_t;

  function automatic int fifo_depth(input int w);
    return 1 << w;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// DEPTH x DATA_BITS storage, one write port and one read port.
// SYNC_RX_FIFO_FWFT_EN makes the read port asynchronous.
module fifo_dpram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDR_BITS);

  logic [DATA_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef SYNC_RX_FIFO_FWFT_EN
  logic unused_rd;
  assign unused_rd = re ^ rst_n;
  assign rdata = mem[raddr];
`else
  // Output register is reset even though the array is not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end
`endif

endmodule

// File: rtl/sync_rx_fifo.sv
// Synchronous receive FIFO with count, flags and sticky errors.
// Define SYNC_RX_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_rx_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_WIDTH = 4,
  parameter int AF_THRESH  = 2**(FIFO_WIDTH-1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] Rx_Data,
  input  logic                 Push,
  input  logic                 Pop,
  input  logic                 Clr_Flags,
  input  logic                 BIST_Mode,
  output logic [DATA_BITS-1:0] Data_Out,
  output logic                 Data_Valid,
  output logic                 FIFO_Empty,
  output logic                 FIFO_Full,
  output logic                 Almost_Full,
  output logic                 FIFO_Overflow,
  output logic                 FIFO_Underflow,
  output logic [FIFO_WIDTH:0]  Count
);

  localparam int DEPTH = fifo_depth(FIFO_WIDTH);

  typedef logic [FIFO_WIDTH:0] cnt_t;

  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);
  localparam cnt_t AF_CNT   = cnt_t'(AF_THRESH);

  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_rx_fifo: AF_THRESH must be within 1..DEPTH");
  end

  logic [FIFO_WIDTH-1:0] wr_ptr;
  logic [FIFO_WIDTH-1:0] rd_ptr;
  cnt_t                  cnt;
  cnt_t                  cnt_nxt;
  fifo_flags_t           flags;
  fifo_flags_t           flags_nxt;
  logic                  act;
  logic                  is_empty;
  logic                  is_full;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  ovf_ev;
  logic                  udf_ev;
  logic [DATA_BITS-1:0]  rdata;

  // A pop on a full FIFO frees the slot the same-cycle push uses.
  always_comb begin
    act      = !BIST_Mode;
    is_empty = (cnt == '0);
    is_full  = (cnt == FULL_CNT);
    pop_ok   = act && Pop && !is_empty;
    push_ok  = act && Push && (!is_full || pop_ok);
    ovf_ev   = act && Push && !push_ok;
    udf_ev   = act && Pop && is_empty;
  end

  always_comb begin
    cnt_nxt = cnt;
    unique case (1'b1)
      (push_ok && !pop_ok): cnt_nxt = cnt + cnt_t'(1);
      (pop_ok && !push_ok): cnt_nxt = cnt - cnt_t'(1);
      default: ;
    endcase
  end

  always_comb begin
    flags_nxt             = '0;
    flags_nxt.empty       = (cnt_nxt == '0);
    flags_nxt.full        = (cnt_nxt == FULL_CNT);
    flags_nxt.almost_full = (cnt_nxt >= AF_CNT);
    flags_nxt.overflow    = ovf_ev |
                            (flags.overflow & !Clr_Flags);
    flags_nxt.underflow   = udf_ev |
                            (flags.underflow & !Clr_Flags);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      flags  <= '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      cnt   <= cnt_nxt;
      flags <= flags_nxt;
    end
  end

  fifo_dpram #(
    .DATA_BITS (DATA_BITS),
    .ADDR_BITS (FIFO_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (Rx_Data),
    .re    (pop_ok),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

`ifdef SYNC_RX_FIFO_FWFT_EN
  assign Data_Out   = flags.empty ? '0 : rdata;
  assign Data_Valid = !flags.empty;
`else
  logic dvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvalid <= 1'b0;
    end else begin
      dvalid <= pop_ok;
    end
  end

  assign Data_Out   = rdata;
  assign Data_Valid = dvalid;
`endif

  assign FIFO_Empty     = flags.empty;
  assign FIFO_Full      = flags.full;
  assign Almost_Full    = flags.almost_full;
  assign FIFO_Overflow  = flags.overflow;
  assign FIFO_Underflow = flags.underflow;
  assign Count          = cnt;

endmodule

// File: tb/tb_sync_rx_fifo.sv
// Randomised and directed bench for sync_rx_fifo against a queue model.
// Honours SYNC_RX_FIFO_FWFT_EN to select the expected read behaviour.
module tb_sync_rx_fifo;

  localparam int DW    = 8;
  localparam int FW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] Rx_Data;
  logic          Push;
  logic          Pop;
  logic          Clr_Flags;
  logic          BIST_Mode;
  logic [DW-1:0] Data_Out;
  logic          Data_Valid;
  logic          FIFO_Empty;
  logic          FIFO_Full;
  logic          Almost_Full;
  logic          FIFO_Overflow;
  logic          FIFO_Underflow;
  logic [FW:0]   Count;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] q[$];
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;
  logic [DW-1:0] m_dout = '0;
  logic          m_dv = 1'b0;

  always #5 clk = ~clk;

  sync_rx_fifo #(
    .DATA_BITS  (DW),
    .FIFO_WIDTH (FW),
    .AF_THRESH  (AF)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .Rx_Data        (Rx_Data),
    .Push           (Push),
    .Pop            (Pop),
    .Clr_Flags      (Clr_Flags),
    .BIST_Mode      (BIST_Mode),
    .Data_Out       (Data_Out),
    .Data_Valid     (Data_Valid),
    .FIFO_Empty     (FIFO_Empty),
    .FIFO_Full      (FIFO_Full),
    .Almost_Full    (Almost_Full),
    .FIFO_Overflow  (FIFO_Overflow),
    .FIFO_Underflow (FIFO_Underflow),
    .Count          (Count)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               name, $time, act, exp);
    end
  endtask

  // Reference model: a plain queue updated by the FIFO rules.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_dout = '0;
        m_dv   = 1'b0;
      end else if (BIST_Mode) begin
        m_dv = 1'b0;
        if (Clr_Flags) begin
          m_ovf = 1'b0;
          m_udf = 1'b0;
        end
      end else begin
        automatic bit emp = (q.size() == 0);
        automatic bit ful = (q.size() == DEPTH);
        automatic bit pa  = Pop && !emp;
        automatic bit wa  = Push && (!ful || pa);
        if (pa) begin
          m_dout = q.pop_front();
          m_dv   = 1'b1;
        end else begin
          m_dv = 1'b0;
        end
        if (wa) q.push_back(Rx_Data);
        if (Push && !wa) m_ovf = 1'b1;
        else if (Clr_Flags) m_ovf = 1'b0;
        if (Pop && emp) m_udf = 1'b1;
        else if (Clr_Flags) m_udf = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        chk("count", Count, q.size());
        chk("empty", FIFO_Empty, q.size() == 0);
        chk("full", FIFO_Full, q.size() == DEPTH);
        chk("almost_full", Almost_Full, q.size() >= AF);
        chk("overflow", FIFO_Overflow, m_ovf);
        chk("underflow", FIFO_Underflow, m_udf);
`ifdef SYNC_RX_FIFO_FWFT_EN
        chk("data_valid", Data_Valid, q.size() != 0);
        if (q.size() != 0) chk("data_out", Data_Out, q[0]);
        else chk("data_out", Data_Out, 0);
`else
        chk("data_valid", Data_Valid, m_dv);
        chk("data_out", Data_Out, m_dout);
`endif
      end
    end
  end

  task automatic apply(input bit p, input bit r,
                       input logic [DW-1:0] d,
                       input bit c, input bit b);
    Push      = p;
    Pop       = r;
    Rx_Data   = d;
    Clr_Flags = c;
    BIST_Mode = b;
    @(posedge clk);
    #1;
    Push      = 1'b0;
    Pop       = 1'b0;
    Clr_Flags = 1'b0;
    BIST_Mode = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    Push      = 1'b0;
    Pop       = 1'b0;
    Rx_Data   = '0;
    Clr_Flags = 1'b0;
    BIST_Mode = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_count", Count, 0);
    chk("rst_empty", FIFO_Empty, 1);
    chk("rst_valid", Data_Valid, 0);
    chk("rst_dout", Data_Out, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Two words in, two words out.
    apply(1, 0, 8'hA5, 0, 0);
    apply(1, 0, 8'h3C, 0, 0);
    chk("t1_count2", Count, 2);
`ifdef SYNC_RX_FIFO_FWFT_EN
    chk("t1_head", Data_Out, 8'hA5);
    chk("t1_hvalid", Data_Valid, 1);
`endif
    apply(0, 1, 0, 0, 0);
    chk("t1_count1", Count, 1);
`ifdef SYNC_RX_FIFO_FWFT_EN
    chk("t1_next", Data_Out, 8'h3C);
`else
    chk("t1_d0", Data_Out, 8'hA5);
    chk("t1_v0", Data_Valid, 1);
    apply(0, 0, 0, 0, 0);
    chk("t1_pulse", Data_Valid, 0);
`endif
    apply(0, 1, 0, 0, 0);
`ifndef SYNC_RX_FIFO_FWFT_EN
    chk("t1_d1", Data_Out, 8'h3C);
`endif
    chk("t1_count0", Count, 0);
    chk("t1_empty", FIFO_Empty, 1);

    // Fill, overflow, drain.
    for (int i = 0; i < 16; i++) begin
      apply(1, 0, 8'(i), 0, 0);
      if (i == 6) chk("t2_af7", Almost_Full, 0);
      if (i == 7) chk("t2_af8", Almost_Full, 1);
      if (i == 14) chk("t2_nfull", FIFO_Full, 0);
    end
    chk("t2_full", FIFO_Full, 1);
    apply(1, 0, 8'hFF, 0, 0);
    chk("t2_ovf", FIFO_Overflow, 1);
    chk("t2_cnt16", Count, 16);
    for (int i = 0; i < 16; i++) begin
`ifdef SYNC_RX_FIFO_FWFT_EN
      chk("t2_head", Data_Out, 8'(i));
      apply(0, 1, 0, 0, 0);
`else
      apply(0, 1, 0, 0, 0);
      chk("t2_rd", Data_Out, 8'(i));
`endif
    end
    chk("t2_ovf_hold", FIFO_Overflow, 1);
    apply(0, 0, 0, 1, 0);
    chk("t2_ovf_clr", FIFO_Overflow, 0);

    // Push and pop together at full and at empty.
    for (int i = 0; i < 16; i++) apply(1, 0, 8'(8'h20 + i), 0, 0);
    apply(1, 1, 8'h55, 0, 0);
    chk("t3_cnt16", Count, 16);
    chk("t3_no_ovf", FIFO_Overflow, 0);
    for (int i = 0; i < 16; i++) apply(0, 1, 0, 0, 0);
`ifndef SYNC_RX_FIFO_FWFT_EN
    chk("t3_last", Data_Out, 8'h55);
`endif
    apply(1, 1, 8'h77, 0, 0);
    chk("t3_udf", FIFO_Underflow, 1);
    chk("t3_cnt1", Count, 1);
    apply(0, 1, 0, 1, 0);

    // Interleaved traffic wraps both pointers.
    for (int i = 0; i < 40; i++) begin
      apply(1, 0, 8'(8'h80 + i), 0, 0);
      apply(0, 1, 0, 0, 0);
`ifndef SYNC_RX_FIFO_FWFT_EN
      chk("t4_rd", Data_Out, 8'(8'h80 + i));
`endif
    end
    chk("t4_ovf", FIFO_Overflow, 0);
    chk("t4_udf", FIFO_Underflow, 0);

    // Frozen while BIST is high.
    for (int i = 0; i < 3; i++) apply(1, 0, 8'(8'hC0 + i), 0, 0);
    for (int i = 0; i < 10; i++)
      apply(1'($urandom), 1'($urandom), 8'($urandom), 0, 1);
    chk("t5_bist_cnt", Count, 3);
    chk("t5_bist_ovf", FIFO_Overflow, 0);
    apply(1, 0, 8'hC3, 0, 0);
    apply(1, 0, 8'hC4, 0, 0);
    chk("t5_cnt5", Count, 5);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_async_cnt", Count, 0);
    chk("t5_async_empty", FIFO_Empty, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

`ifdef SYNC_RX_FIFO_FWFT_EN
    apply(1, 0, 8'h12, 0, 0);
    chk("t6_dout", Data_Out, 8'h12);
    chk("t6_valid", Data_Valid, 1);
    apply(0, 1, 0, 0, 0);
    chk("t6_nvalid", Data_Valid, 0);
    chk("t6_empty", FIFO_Empty, 1);
`endif

    // Random traffic, push-heavy then pop-heavy.
    for (int i = 0; i < 600; i++) begin
      automatic int pw = (i < 300) ? 70 : 30;
      apply($urandom_range(0, 99) < pw,
            $urandom_range(0, 99) < (100 - pw),
            8'($urandom),
            $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) < 5);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
